reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Debug read-side sequencer for the processor register file. On a start pulse it walks an index range over the register file's debug read port (`Debug_Source_select` / `Debug_out`), captures each register value and streams it out over a valid/ready interface tagged with its index. The block sits between the register file and the board debug/host link, so register state can be dumped without stalling the datapath's two architectural read ports.

## Interface
- `WIDTH`, 32: register data width; must match the register file.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`=1.
- `first_idx`  in  5  first register index; sampled when `start` is accepted.
- `last_idx`  in  5  final register index; sampled when `start` is accepted.
- `abort`  in  1  terminates the dump in progress.
- `Debug_Source_select`  out  5  registered index driven to the register file debug mux.
- `Debug_out`  in  WIDTH  combinational debug read data from the register file.
- `out_valid`  out  1  `out_data`/`out_index`/`out_last` are valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid`&`out_ready`.
- `out_data`  out  WIDTH  captured register value.
- `out_index`  out  5  index of `out_data`.
- `out_last`  out  1  word is for `last_idx`.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE: `start`=1 → latch `first_idx`/`last_idx`, load `Debug_Source_select`←`first_idx`, `busy`←1, go FETCH.
- FETCH: capture `out_data`←`Debug_out`, `out_index`←`Debug_Source_select`, `out_last`←(index==`last_idx`); assert `out_valid`; go SEND.
- SEND: hold all outputs stable while `out_ready`=0. On handshake: if `out_last`, go FINISH; else increment `Debug_Source_select` modulo 32 and go FETCH.
- FINISH: `done`=1 for one cycle, `busy`←0, go IDLE.
- Range: index increments 5-bit, wrapping 31→0; `first_idx`>`last_idx` dumps first..31, 0..last. `first_idx`==`last_idx` yields exactly one word with `out_last`=1.
- Captured data is a snapshot at FETCH; register file writes after capture do not alter the held word.
- `abort`=1 in any non-IDLE state: next state IDLE, `out_valid`←0, `busy`←0, no `done` pulse; overrides a same-cycle handshake. `abort` in IDLE has no effect; `abort` and `start` together in IDLE: `start` wins.
- `start` while `busy`=1: ignored, latched range unchanged.

## Timing
- Reset (async assert, sync release): `Debug_Source_select`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE.
- `start` at edge N → `busy`=1 after N, `out_valid`=1 after N+1.
- Minimum 2 cycles per word (FETCH + SEND with `out_ready` held 1); full 32-register dump = 64 cycles from first FETCH to final handshake, `done` high the cycle after.
- `out_valid` never deasserts without a handshake except on `abort` or reset.

## Configuration
- `REG_DUMP_SPARSE_EN` defined: in FETCH, if `Debug_out`==0 and index≠`last_idx`, no word is emitted; index increments and FSM stays in FETCH (1 cycle per skipped register). Index `last_idx` is always emitted, so `out_last` and `done` always occur.
- Not defined: every register in range is emitted, including zero values.

## Test plan
- Reset mid-dump (`out_valid`=1) → all outputs return to reset values immediately; next `start` dumps normally.
- Registers loaded with 0x100+i, `start` first=0 last=31, `out_ready`=1 → 32 words, index 0..31, data 0x100..0x11F, `out_last` only on index 31, `done` pulse at cycle 65 after `start`.
- first=30, last=1 with random `out_ready` stalls → indices 30,31,0,1 in order, data stable during stalls, exactly 4 handshakes.
- first=last=5 → single word index 5, `out_last`=1; write to x5 during SEND does not change `out_data`.
- `abort` during SEND of index 3 with `out_ready`=1 → no handshake counted, `out_valid`=0 and `busy`=0 next cycle, no `done`; `start` during busy ignored.
- `REG_DUMP_SPARSE_EN`, only x2=7 and x9=0 nonzero-else, first=0 last=9 → words (2,7) and (9,0,`out_last`=1), then `done`.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file index range over the debug read port and streams each value out on a valid/ready link.
// Optional feature macro: REG_DUMP_SPARSE_EN (skip zero-valued registers other than last_idx).
`default_nettype none

module reg_dump_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       first_idx,
  input  logic [4:0]       last_idx,
  input  logic             abort,
  output logic [4:0]       Debug_Source_select,
  input  logic [WIDTH-1:0] Debug_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] last_sel;
  logic       at_last;
  logic       skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    at_last = (Debug_Source_select == last_sel);
`ifdef REG_DUMP_SPARSE_EN
    skip    = (Debug_out == '0) && !at_last;
`else
    skip    = 1'b0;
`endif
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (abort)      state_next = IDLE;
        else if (!skip) state_next = SEND;
      end
      SEND: begin
        // abort takes priority over a handshake landing on the same edge
        if (abort)          state_next = IDLE;
        else if (out_ready) state_next = out_last ? FINISH : FETCH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Debug_Source_select <= 5'd0;
      last_sel            <= 5'd0;
      out_valid           <= 1'b0;
      out_data            <= '0;
      out_index           <= 5'd0;
      out_last            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_sel            <= last_idx;
            Debug_Source_select <= first_idx;
            busy                <= 1'b1;
          end
        end
        FETCH: begin
          if (abort) begin
            busy <= 1'b0;
          end else if (skip) begin
            Debug_Source_select <= Debug_Source_select + 5'd1;
          end else begin
            out_data  <= Debug_out;
            out_index <= Debug_Source_select;
            out_last  <= at_last;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) done <= 1'b1;
            else          Debug_Source_select <= Debug_Source_select + 5'd1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench; a register-file model feeds the debug port and a monitor checks every presented word.
`timescale 1ns/1ps

module tb_reg_dump_reader;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       first_idx = 5'd0;
  logic [4:0]       last_idx = 5'd0;
  logic             abort = 1'b0;
  logic [4:0]       Debug_Source_select;
  logic [WIDTH-1:0] Debug_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_index;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [31:0] regs [32];
  word_t       sb [$];
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;

  assign Debug_out = regs[Debug_Source_select];

  reg_dump_reader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .Debug_Source_select(Debug_Source_select), .Debug_out(Debug_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk f..l with 5-bit wraparound, sparse mode drops zeros except the final index.
  function automatic void build_expected(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] i;
    bit emit;
    i = f;
    for (int k = 0; k < 32; k++) begin
      emit = 1'b1;
`ifdef REG_DUMP_SPARSE_EN
      if (regs[i] == 32'd0 && i != l) emit = 1'b0;
`endif
      if (emit) sb.push_back('{idx: i, data: regs[i], last: (i == l)});
      if (i == l) break;
      i = i + 5'd1;
    end
  endfunction

  // Monitor: every presented word (stalled or accepted) must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && out_valid && !abort) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got idx %0d data %0h, none expected", out_index, out_data);
      end else begin
        chk("word_index", {59'd0, out_index}, {59'd0, sb[0].idx});
        chk("word_data", {32'd0, out_data}, {32'd0, sb[0].data});
        chk("word_last", {63'd0, out_last}, {63'd0, sb[0].last});
        if (out_ready) begin
          void'(sb.pop_front());
          hs_count++;
        end
      end
    end
  end

  // mode 0: ready always; 1: random ready; 2: stall, overwrite the register after capture, then accept.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit inject_start, output int cyc);
    int  n, hs0;
    bit  got;
    logic [31:0] saved;
    sb.delete();
    build_expected(f, l);
    n   = sb.size();
    hs0 = hs_count;
    saved = regs[f];
    start = 1'b1; first_idx = f; last_idx = l;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    got = 1'b0;
    while (cyc < 500) begin
      start = inject_start && (cyc == 1);
      if (start) begin first_idx = f + 5'd7; last_idx = f + 5'd9; end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = $urandom_range(0, 1);
        default: begin
          out_ready = (cyc >= 5);
          if (cyc == 2) regs[f] = ~regs[f];
        end
      endcase
      @(posedge clk); #1;
      cyc++;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    regs[f] = saved;
    chk("done_seen", {63'd0, got}, 64'd1);
    chk("handshakes", 64'(hs_count - hs0), 64'(n));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    chk("done_single_cycle", {63'd0, done}, 64'd0);
    chk("busy_cleared", {63'd0, busy}, 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"}, {59'd0, Debug_Source_select}, 64'd0);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
    chk({tag, "_index"}, {59'd0, out_index}, 64'd0);
    chk({tag, "_last"}, {63'd0, out_last}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int  cyc, hs0;
    bit  seen;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    // Full 32-register dump with ready held high
    run_dump(5'd0, 5'd31, 0, 1'b0, cyc);
    chk("full_dump_latency", 64'(cyc), 64'd64);

    // Wrapping range with random stalls
    run_dump(5'd30, 5'd1, 1, 1'b0, cyc);

    // Single word; register overwritten while the word is held
    run_dump(5'd5, 5'd5, 2, 1'b0, cyc);

    // start while busy must not disturb the latched range
    run_dump(5'd4, 5'd6, 0, 1'b1, cyc);

    // Abort while index 3 is presented with ready high
    sb.delete();
    build_expected(5'd0, 5'd10);
    hs0 = hs_count;
    start = 1'b1; first_idx = 5'd0; last_idx = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd3) begin seen = 1'b1; break; end
    end
    chk("abort_reached_index3", {63'd0, seen}, 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_handshakes", 64'(hs_count - hs0), 64'd3);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    out_ready = 1'b0;
    sb.delete();

    // Asynchronous reset while a word is held
    start = 1'b1; first_idx = 5'd7; last_idx = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("reset_test_valid_seen", {63'd0, seen}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    run_dump(5'd7, 5'd12, 0, 1'b0, cyc);

    // Mostly-zero register file
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[2] = 32'd7;
    run_dump(5'd0, 5'd9, 1, 1'b0, cyc);

    // Random contents and ranges
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++)
        regs[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1'b0, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
